// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_WDONE  = 2'd3
  } state_t;

  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;
  localparam int OFF_W     = $clog2(WORDS_DEF);
  localparam int IDX_W     = $clog2(LINES_DEF);
  localparam int TAG_W     = 30 - OFF_W - IDX_W;

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: combinational read port, one word write port, tag+valid strobe.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int OW    = OFF_W,
  parameter int IW    = IDX_W,
  parameter int TW    = TAG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  input  logic [OW-1:0] rd_off,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [OW-1:0] wr_off,
  input  logic [31:0]   wr_data,
  input  logic          tv_we,
  input  logic [TW-1:0] tv_tag
);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < LINES; i++) tag_mem[i] <= '0;
    end else if (tv_we) begin
      valid[wr_idx]   <= 1'b1;
      tag_mem[wr_idx] <= tv_tag;
    end
  end

  // Data words carry no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_off}] <= wr_data;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through D-cache controller: read hits, 4-word line refills, store forwarding.
// Memory handshake: a word moves on any cycle where mem_req && mem_ack; mem_ack is ignored otherwise.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output state_t      dbg_state
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  state_t        state;
  logic [OW-1:0] cnt;
  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          lk_valid;
  logic [TW-1:0] lk_tag;
  logic [31:0]   lk_data;
  logic          lookup_hit;
  logic          ack;
  logic          last;
  logic          d_we;
  logic [OW-1:0] d_off;
  logic [31:0]   d_data;
  logic          t_we;
  logic          unused_addr_lsb;

  assign off             = cpu_addr[OW+1:2];
  assign idx             = cpu_addr[OW+IW+1:OW+2];
  assign tag             = cpu_addr[31:OW+IW+2];
  assign unused_addr_lsb = ^cpu_addr[1:0];
  assign lookup_hit      = lk_valid && (lk_tag == tag);
  assign ack             = mem_req && mem_ack;
  assign last            = (cnt == OW'(WORDS - 1));
  assign dbg_state       = state;

  dcache_line_store #(
    .LINES(LINES), .WORDS(WORDS), .OW(OW), .IW(IW), .TW(TW)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_off   (off),
    .rd_valid (lk_valid),
    .rd_tag   (lk_tag),
    .rd_data  (lk_data),
    .wr_en    (d_we),
    .wr_idx   (idx),
    .wr_off   (d_off),
    .wr_data  (d_data),
    .tv_we    (t_we),
    .tv_tag   (tag)
  );

  // Refill fills words in counter order; a store only touches the line when it already holds the tag.
  always_comb begin
    d_we   = 1'b0;
    d_off  = off;
    d_data = cpu_wdata;
    t_we   = 1'b0;
    case (state)
      ST_REFILL: begin
        d_we   = ack;
        d_off  = cnt;
        d_data = mem_rdata;
        t_we   = ack && last;
      end
      ST_WRITE: d_we = ack && lookup_hit;
      default: ;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    case (state)
      ST_IDLE:  hit = cpu_wr ? 1'b0 : (cpu_rd ? lookup_hit : 1'b1);
      ST_WDONE: hit = 1'b1;
      default:  hit = 1'b0;
    endcase
  end

  assign cpu_rdata = (state == ST_IDLE && cpu_rd && !cpu_wr && lookup_hit) ? lk_data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_wr) begin
            state     <= ST_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {cpu_addr[31:2], 2'b00};
            mem_wdata <= cpu_wdata;
          end else if (cpu_rd && !lookup_hit) begin
            state    <= ST_REFILL;
            cnt      <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {tag, idx, {OW{1'b0}}, 2'b00};
          end
        end
        ST_REFILL: begin
          if (ack) begin
            if (last) begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        ST_WRITE: begin
          if (ack) begin
            state   <= ST_WDONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        // One hit cycle so a store still held by the MEM stage is not issued twice.
        ST_WDONE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
